// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Holds the fetch PC, advances it by STEP on each accepted fetch, and arbitrates
// trap > branch > return redirects. A small circular return-address stack supplies
// return targets; when it is empty the caller-provided fallback address is used.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     STALL_W   = 5,
    parameter int unsigned     STALL_BIT = 2,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [STALL_W-1:0] do_stall,
    input  logic               fetch_ready,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_addr,
    input  logic               branch,
    input  logic [XLEN-1:0]    branch_addr,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_fallback_addr,
    input  logic               call_valid,
    input  logic [XLEN-1:0]    call_link,
    output logic [XLEN-1:0]    pc_cpu,
    output logic               pc_valid,
    output logic               redirected,
    output logic               misaligned,
    output logic               ras_empty
);

    localparam int unsigned     ALIGN_W  = $clog2(STEP);
    localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W    = $clog2(RAS_DEPTH + 1);
    // Bits of a redirect target that must be zero for an aligned fetch
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_W) - 64'd1);
    localparam logic [XLEN-1:0] STEP_X   = XLEN'(STEP);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // PC state
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirected_q, redirected_d;
    logic            misaligned_q, misaligned_d;

    // RAS state: top_q points at the most recent entry
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ras_we;
    logic [PTR_W-1:0] ras_widx;

    logic            accept;
    logic            ras_nonempty;
    logic [XLEN-1:0] ras_top;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            do_push;
    logic            do_pop;

    // Only STALL_BIT affects the PC; other stall bits belong to other stages
    logic unused_stall;
    assign unused_stall = ^do_stall;

    assign pc_valid     = go & reset & ~do_stall[STALL_BIT];
    assign accept       = pc_valid & fetch_ready;
    assign ras_nonempty = (cnt_q != '0);
    assign ras_top      = ras_q[top_q];

    assign pc_cpu     = pc_q;
    assign redirected = redirected_q;
    assign misaligned = misaligned_q;
    assign ras_empty  = ~ras_nonempty;

    // Next-PC selection: redirects bypass stall and fetch_ready, go gates everything
    always_comb begin
        redirect     = 1'b0;
        target       = '0;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        redirected_d = 1'b0;
        if (go) begin
            if (trap_valid) begin
                redirect = 1'b1;
                target   = trap_addr;
            end else if (branch) begin
                redirect = 1'b1;
                target   = branch_addr;
            end else if (ret_valid) begin
                redirect = 1'b1;
                target   = ras_nonempty ? ras_top : ret_fallback_addr;
            end else if (accept) begin
                pc_d = pc_q + STEP_X;
            end
            if (redirect) begin
                pc_d         = target & ~LOW_MASK;
                misaligned_d = |(target & LOW_MASK);
                redirected_d = 1'b1;
            end
        end
    end

    // RAS next-state: trap suppresses all updates, a ret losing to branch does not pop
    always_comb begin
        do_push  = go & ~trap_valid & call_valid;
        do_pop   = go & ~trap_valid & ~branch & ret_valid & ras_nonempty;
        top_d    = top_q;
        cnt_d    = cnt_q;
        ras_we   = 1'b0;
        ras_widx = top_q;
        if (do_push && do_pop) begin
            // Return consumed the old top; the call link takes its slot
            ras_we   = 1'b1;
            ras_widx = top_q;
        end else if (do_push) begin
            ras_we   = 1'b1;
            ras_widx = top_q + PTR_W'(1);
            top_d    = top_q + PTR_W'(1);
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // PC and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_VEC;
            redirected_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            redirected_q <= redirected_d;
            misaligned_q <= misaligned_d;
        end
    end

    // RAS pointer, count and storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (ras_we) begin
                ras_q[ras_widx] <= call_link;
            end
        end
    end

endmodule
